// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;

  // Prefetch queue entry; the pc field is FETCH_XLEN wide.
  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc;
    logic                  exc_req;
    logic [3:0]            exc_code;
  } type_fpq_entry_s;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MIS  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pq.sv
// Generic synchronous FIFO with flush and occupancy count. Storage is not reset;
// only pointers and count are.
module fetch_pq #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;

  // Explicit wrap so non-power-of-two depths (the pc shadow) also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop_ok)      count <= count + CW'(1);
      else if (!push && pop_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with a prefetch queue, credit-limited outstanding icache
// requests, redirect flush/kill and misaligned/access-fault exception entries.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int               XLEN     = FETCH_XLEN,
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUT  = 2,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0000_1000)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            ic_req_o,
  output logic [XLEN-1:0] ic_addr_o,
  input  logic            ic_ready_i,
  output logic            ic_kill_o,
  input  logic            ic_ack_i,
  input  logic [31:0]     ic_rdata_i,
  input  logic            ic_fault_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic            id_exc_req_o,
  output logic [3:0]      id_exc_code_o
);

  localparam int OCW = $clog2(DEPTH + 1);
  localparam int SCW = $clog2(MAX_OUT + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic            started;

  logic            req_cand, ack_v, fault_ack, accept, mis_push;
  logic [OCW-1:0]  occ;
  logic [SCW-1:0]  out_cnt;
  logic            q_empty, sh_empty;
  logic [XLEN-1:0] sh_head;
  type_fpq_entry_s q_head, push_entry;

  // Credit check covers in-flight requests so an ack always finds a free slot.
  always_comb begin
    req_cand  = started && (state_q == ST_RUN) &&
                (32'(out_cnt) < 32'(MAX_OUT)) &&
                ((32'(occ) + 32'(out_cnt)) < 32'(DEPTH));
    ack_v     = ic_ack_i && !sh_empty && !redirect_i;
    fault_ack = ack_v && ic_fault_i;
    ic_req_o  = req_cand && !redirect_i && !fault_ack;
    accept    = ic_req_o && ic_ready_i;
    ic_kill_o = redirect_i ? (!sh_empty || req_cand) : fault_ack;
    mis_push  = (state_q == ST_MIS) && !redirect_i;
  end

  assign ic_addr_o = fetch_pc;

  always_comb begin
    push_entry.instr    = ic_rdata_i;
    push_entry.pc       = FETCH_XLEN'(sh_head);
    push_entry.exc_req  = ic_fault_i;
    push_entry.exc_code = ic_fault_i ? EXC_INSTR_ACCESS_FAULT : EXC_INSTR_MISALIGNED;
    if (!ack_v) begin
      push_entry.instr    = NOP_INSTR;
      push_entry.pc       = FETCH_XLEN'(fetch_pc);
      push_entry.exc_req  = 1'b1;
      push_entry.exc_code = EXC_INSTR_MISALIGNED;
    end
  end

  fetch_pq #(
    .DEPTH (DEPTH),
    .DATA_W($bits(type_fpq_entry_s))
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_i),
    .push     (ack_v || mis_push),
    .push_data(push_entry),
    .pop      (id_valid_o && id_ready_i),
    .head_data(q_head),
    .count    (occ),
    .empty    (q_empty)
  );

  // Shadow of request addresses; its count is the outstanding-request counter.
  fetch_pq #(
    .DEPTH (MAX_OUT),
    .DATA_W(XLEN)
  ) u_pc_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_i || fault_ack),
    .push     (accept),
    .push_data(fetch_pc),
    .pop      (ack_v),
    .head_data(sh_head),
    .count    (out_cnt),
    .empty    (sh_empty)
  );

  always_comb begin
    id_valid_o    = !q_empty;
    id_instr_o    = id_valid_o ? q_head.instr : NOP_INSTR;
    id_pc_o       = id_valid_o ? XLEN'(q_head.pc) : '0;
    id_exc_req_o  = id_valid_o && q_head.exc_req;
    id_exc_code_o = id_valid_o ? q_head.exc_code : 4'd0;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      state_d    = (redirect_pc_i[1:0] != 2'b00) ? ST_MIS : ST_RUN;
    end else begin
      if (accept)                    fetch_pc_d = fetch_pc + XLEN'(4);
      if (fault_ack)                 state_d    = ST_HALT;
      else if (state_q == ST_MIS)    state_d    = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      fetch_pc <= RESET_PC;
      started  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= fetch_pc_d;
      started  <= 1'b1;
    end
  end

endmodule
